// File: rtl/rx_deserializer_if.sv
// rx_deserializer_if: serial sample input, byte FIFO output and error flags of the receive deserializer.
interface rx_deserializer_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          din;
    logic                          sample_sig;
    logic [DATA_BITS-1:0]          data_out;
    logic                          data_valid;
    logic                          data_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overrun;
    logic                          frame_err;
    logic                          clear_err;

    modport slave (
        input  din, sample_sig, data_ready, clear_err,
        output data_out, data_valid, fifo_count, overrun, frame_err
    );

    modport master (
        output din, sample_sig, data_ready, clear_err,
        input  data_out, data_valid, fifo_count, overrun, frame_err
    );
endinterface

// File: rtl/rx_deserializer.sv
// rx_deserializer: LSB-first byte assembler with strobe-gap abort, feeding a small valid/ready FIFO.
module rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_LIMIT  = 40
) (
    input logic              sample_clk,
    input logic              rst_n,
    rx_deserializer_if.slave bus
);
    localparam int BW = $clog2(DATA_BITS);
    localparam int GW = $clog2(GAP_LIMIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, SHIFTING} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [DATA_BITS-1:0] shifted;
    logic                 last, pop, full, push_ok, drop, gap_abort;

    always_comb begin
        shifted   = {bus.din, shift_q[DATA_BITS-1:1]};
        last      = bus.sample_sig && bit_cnt_q == BW'(DATA_BITS - 1);
        pop       = count_q != '0 && bus.data_ready;
        full      = count_q == CW'(FIFO_DEPTH);
        // a full FIFO still takes the byte when the head leaves on the same edge
        push_ok   = last && (!full || pop);
        drop      = last && full && !pop;
        gap_abort = state_q == SHIFTING && !bus.sample_sig && gap_cnt_q == GW'(GAP_LIMIT - 1);
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        if (bus.sample_sig) begin
            shift_d   = shifted;
            gap_cnt_d = '0;
            bit_cnt_d = last ? '0 : bit_cnt_q + 1'b1;
            state_d   = last ? IDLE : SHIFTING;
        end else if (state_q == SHIFTING) begin
            shift_d   = gap_abort ? '0 : shift_q;
            bit_cnt_d = gap_abort ? '0 : bit_cnt_q;
            gap_cnt_d = gap_abort ? '0 : gap_cnt_q + 1'b1;
            state_d   = gap_abort ? IDLE : SHIFTING;
        end
        wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CW'(push_ok) - CW'(pop);
        overrun_d   = drop || (overrun_q && !bus.clear_err);
        frame_err_d = gap_abort || (frame_err_q && !bus.clear_err);
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            if (push_ok) mem_q[wr_ptr_q] <= shifted;
        end
    end

    assign bus.data_out   = mem_q[rd_ptr_q];
    assign bus.data_valid = count_q != '0;
    assign bus.fifo_count = count_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_rx_deserializer.sv
// tb_rx_deserializer: directed checks of byte assembly, FIFO flow control, gap abort and error flags.
module tb_rx_deserializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    rx_deserializer_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus();

    rx_deserializer #(.DATA_BITS(8), .FIFO_DEPTH(4), .GAP_LIMIT(40)) dut (
        .sample_clk(clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // one strobe; optional ready/clear held on the same edge
    task automatic strobe(input logic b, input logic rdy, input logic clr);
        @(posedge clk); #1;
        bus.din = b; bus.sample_sig = 1'b1; bus.data_ready = rdy; bus.clear_err = clr;
        @(posedge clk); #1;
        bus.sample_sig = 1'b0; bus.data_ready = 1'b0; bus.clear_err = 1'b0;
    endtask

    // strobes 16 cycles apart; returns just after the completing edge
    task automatic send_byte(input logic [7:0] v, input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            strobe(v[i], i == 7 ? rdy_last : 1'b0, i == 7 ? clr_last : 1'b0);
            if (i < 7) idle(14);
        end
    endtask

    task automatic pop_one();
        @(posedge clk); #1;
        bus.data_ready = 1'b1;
        @(posedge clk); #1;
        bus.data_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        bus.clear_err = 1'b1;
        @(posedge clk); #1;
        bus.clear_err = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        bus.din = 1'b0; bus.sample_sig = 1'b0; bus.data_ready = 1'b0; bus.clear_err = 1'b0;
        idle(2);
        check("rst_valid", bus.data_valid, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_flags", {bus.overrun, bus.frame_err}, 0);
        rst_n = 1'b1;
        idle(2);

        send_byte(8'hA5, 1'b0, 1'b0);
        check("t1_valid", bus.data_valid, 1);
        check("t1_data", bus.data_out, 8'hA5);
        check("t1_count", bus.fifo_count, 1);
        pop_one();
        check("t1_pop_valid", bus.data_valid, 0);

        for (int k = 1; k <= 5; k++) send_byte(8'(k), 1'b0, 1'b0);
        check("t2_count", bus.fifo_count, 4);
        check("t2_overrun", bus.overrun, 1);
        for (int k = 1; k <= 4; k++) begin
            check("t2_drain", bus.data_out, k);
            pop_one();
        end
        check("t2_empty", bus.fifo_count, 0);
        pulse_clear();
        check("t2_clear", bus.overrun, 0);

        strobe(1'b1, 1'b0, 1'b0); idle(14);
        strobe(1'b0, 1'b0, 1'b0); idle(14);
        strobe(1'b1, 1'b0, 1'b0);
        idle(39);
        check("t3_before_limit", bus.frame_err, 0);
        idle(1);
        check("t3_frame_err", bus.frame_err, 1);
        check("t3_count", bus.fifo_count, 0);
        send_byte(8'h3C, 1'b0, 1'b0);
        check("t3_data", bus.data_out, 8'h3C);
        check("t3_count2", bus.fifo_count, 1);
        pop_one();
        pulse_clear();
        check("t3_clear", bus.frame_err, 0);

        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        send_byte(8'h55, 1'b1, 1'b0);
        check("t4_overrun", bus.overrun, 0);
        check("t4_count", bus.fifo_count, 4);
        foreach (exp_q[k]) begin
            check("t4_drain", bus.data_out, exp_q[k]);
            pop_one();
        end
        check("t4_empty", bus.data_valid, 0);

        send_byte(8'h77, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin strobe(1'b1, 1'b0, 1'b0); idle(14); end
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", bus.data_valid, 0);
        check("t5_count", bus.fifo_count, 0);
        check("t5_data", bus.data_out, 0);
        check("t5_flags", {bus.overrun, bus.frame_err}, 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        send_byte(8'hFF, 1'b0, 1'b0);
        check("t5_ff", bus.data_out, 8'hFF);
        check("t5_count2", bus.fifo_count, 1);
        pop_one();

        for (int k = 0; k < 4; k++) send_byte(8'h60 + 8'(k), 1'b0, 1'b0);
        check("t6_pre", bus.overrun, 0);
        send_byte(8'h99, 1'b0, 1'b1);
        check("t6_overrun", bus.overrun, 1);
        check("t6_head", bus.data_out, 8'h60);
        pulse_clear();
        check("t6_clear", bus.overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
